rapid_data_mem: RTL

RAPID_DATA_MEM -- requirements
Module: rapid_data_mem

---
 rtl/rapid_data_mem.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/rapid_data_mem.sv
// Single-port load/store data memory with a valid/ready request/response handshake
// and a fixed response latency. Byte, half and word accesses use little-endian lanes.
module rapid_data_mem #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [1:0]      i_req_size,
    input  logic            i_req_unsigned,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic [XLEN-1:0] o_rsp_rdata,
    output logic            o_rsp_error
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int unsigned NB = XLEN / 8;
    localparam logic [XLEN:0] ADDR_LIMIT = (XLEN+1)'(DEPTH_WORDS) << 2;
    localparam bit DIRECT = (LATENCY == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_wdata;

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic            accept;
    logic            enter_resp;
    logic            commit;
    logic            cur_we;
    logic [XLEN-1:0] cur_addr;
    logic [1:0]      cur_size;
    logic            cur_unsigned;
    logic [XLEN-1:0] cur_wdata;
    logic            cur_err;
    logic [AW-1:0]   idx;
    logic [1:0]      lane;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] rsp_next;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wr_data;

    assign o_req_ready = (state == IDLE) && !i_reset;
    assign accept      = i_req_valid && o_req_ready;

    // With zero latency the access resolves in the acceptance cycle, so use live inputs in IDLE.
    assign cur_we       = (state == IDLE) ? i_req_we       : req_we;
    assign cur_addr     = (state == IDLE) ? i_req_addr     : req_addr;
    assign cur_size     = (state == IDLE) ? i_req_size     : req_size;
    assign cur_unsigned = (state == IDLE) ? i_req_unsigned : req_unsigned;
    assign cur_wdata    = (state == IDLE) ? i_req_wdata    : req_wdata;

    assign idx  = cur_addr[AW+1:2];
    assign lane = cur_addr[1:0];

    always_comb begin
        cur_err = 1'b0;
        case (cur_size)
            2'b01:   cur_err = cur_addr[0];
            2'b10:   cur_err = |cur_addr[1:0];
            2'b11:   cur_err = 1'b1;
            default: cur_err = 1'b0;
        endcase
        if ({1'b0, cur_addr} >= ADDR_LIMIT) begin
            cur_err = 1'b1;
        end
    end

    // Lane-align the addressed word, then extend to XLEN.
    always_comb begin
        shifted  = mem[idx] >> {lane, 3'b000};
        load_ext = shifted;
        case (cur_size)
            2'b00: load_ext = cur_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                           : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = cur_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                           : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        rsp_next = (cur_we || cur_err) ? '0 : load_ext;
    end

    always_comb begin
        be = '1;
        case (cur_size)
            2'b00:   be = NB'(1) << lane;
            2'b01:   be = NB'(3) << lane;
            default: be = '1;
        endcase
        wr_data = cur_wdata << {lane, 3'b000};
    end

    assign enter_resp = ((state == WAIT) && (cnt == '0)) || (DIRECT && accept);
    assign commit     = enter_resp && cur_we && !cur_err && !i_reset;

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (commit) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_rdata  <= '0;
            o_rsp_error  <= 1'b0;
            req_we       <= 1'b0;
            req_addr     <= '0;
            req_size     <= 2'b00;
            req_unsigned <= 1'b0;
            req_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_we       <= i_req_we;
                        req_addr     <= i_req_addr;
                        req_size     <= i_req_size;
                        req_unsigned <= i_req_unsigned;
                        req_wdata    <= i_req_wdata;
                        if (DIRECT) begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_rdata <= rsp_next;
                            o_rsp_error <= cur_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LATENCY);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state       <= RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_rdata <= rsp_next;
                        o_rsp_error <= cur_err;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                        o_rsp_rdata <= '0;
                        o_rsp_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
